// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment codes and FSM encoding for the 7-segment scan controller.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // Active-low {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SHIFT,
        ST_STORE,
        ST_COMMIT
    } state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        return (code > 4'd9) ? SEG_BLANK : SEG_DIGIT[code];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble, one bit per cycle after start; done is high during the final shift.
// Keeps one extra decimal digit internally so values that do not fit DIGITS are flagged as overflow.
module bin2bcd_seq #(
    parameter int VAL_W  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [VAL_W-1:0]      value,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  overflow
);
    localparam int ND = DIGITS + 1;
    localparam int CW = $clog2(VAL_W + 1);

    logic [VAL_W-1:0] sh;
    logic [ND*4-1:0]  acc;
    logic [ND*4-1:0]  adj;
    logic [CW-1:0]    cnt;

    always_comb begin
        adj = acc;
        for (int d = 0; d < ND; d++)
            adj[d*4 +: 4] = (acc[d*4 +: 4] >= 4'd5) ? acc[d*4 +: 4] + 4'd3 : acc[d*4 +: 4];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh  <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (start) begin
            sh  <= value;
            acc <= '0;
            cnt <= CW'(VAL_W);
        end else if (cnt != '0) begin
            {acc, sh} <= {adj, sh} << 1;
            cnt       <= cnt - 1'b1;
        end
    end

    assign done     = (cnt == CW'(1));
    assign bcd      = acc[DIGITS*4-1:0];
    assign overflow = (acc[ND*4-1 -: 4] != 4'd0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: converts NUM_CH binary values to decimal and scans them onto one 7-segment bus.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros of each channel (LSD always shown).
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int VAL_W         = 6,
    parameter int DIGITS_PER_CH = 2,
    parameter int REFRESH_DIV   = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_CH*VAL_W-1:0]           in_data,
    output logic                              busy,
    output logic [NUM_CH*DIGITS_PER_CH-1:0]   anode,
    output logic [6:0]                        segment
);
    localparam int TOTAL_DIG = NUM_CH * DIGITS_PER_CH;
    localparam int SW        = TOTAL_DIG * 5;
    localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IW        = (TOTAL_DIG > 1) ? $clog2(TOTAL_DIG) : 1;
    localparam int PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    if (2**VAL_W > 10**(DIGITS_PER_CH + 1)) begin : g_range_err
        $error("VAL_W too wide for DIGITS_PER_CH+1 decimal digits");
    end
    if (REFRESH_DIV < 1) begin : g_div_err
        $error("REFRESH_DIV must be at least 1");
    end

    state_t                      state;
    logic [CW-1:0]               ch;
    logic [NUM_CH*VAL_W-1:0]     cap;
    logic [SW-1:0]               shadow;
    logic [SW-1:0]               disp;
    logic                        done;
    logic                        ovf;
    logic [DIGITS_PER_CH*4-1:0]  bcd;
    logic [DIGITS_PER_CH*5-1:0]  ch_dig;
    logic [PW-1:0]               pre;
    logic [IW-1:0]               idx;
    logic [4:0]                  cur;

    assign in_ready = (state == ST_IDLE);
    assign busy     = !in_ready;

    bin2bcd_seq #(.VAL_W(VAL_W), .DIGITS(DIGITS_PER_CH)) u_conv (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (state == ST_INIT),
        .value    (cap[VAL_W-1:0]),
        .done     (done),
        .bcd      (bcd),
        .overflow (ovf)
    );

    // Each digit slot is {dash, code}; codes 10-15 decode to blank.
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    always_comb begin
        ch_dig = '0;
        lead   = 1'b1;
        for (int p = DIGITS_PER_CH - 1; p >= 0; p--) begin
            lead = lead && (bcd[p*4 +: 4] == 4'd0) && (p != 0);
            ch_dig[p*5 +: 5] = ovf ? 5'h10 : {1'b0, lead ? 4'hF : bcd[p*4 +: 4]};
        end
    end
`else
    always_comb begin
        ch_dig = '0;
        for (int p = 0; p < DIGITS_PER_CH; p++)
            ch_dig[p*5 +: 5] = ovf ? 5'h10 : {1'b0, bcd[p*4 +: 4]};
    end
`endif

    // Channels are converted in order and shifted in from the top, so channel 0 ends at digit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            ch     <= '0;
            cap    <= '0;
            shadow <= {TOTAL_DIG{5'h0F}};
            disp   <= {TOTAL_DIG{5'h0F}};
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    cap   <= in_data;
                    ch    <= '0;
                    state <= ST_INIT;
                end
                ST_INIT:  state <= ST_SHIFT;
                ST_SHIFT: state <= done ? ST_STORE : ST_SHIFT;
                ST_STORE: begin
                    shadow <= SW'({ch_dig, shadow} >> (DIGITS_PER_CH * 5));
                    cap    <= cap >> VAL_W;
                    ch     <= ch + 1'b1;
                    state  <= (ch == CW'(NUM_CH - 1)) ? ST_COMMIT : ST_INIT;
                end
                ST_COMMIT: begin
                    disp  <= shadow;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cur = 5'(disp >> (idx * 5));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre     <= '0;
            idx     <= '0;
            anode   <= '1;
            segment <= SEG_BLANK;
        end else begin
            pre     <= (pre == PW'(REFRESH_DIV - 1)) ? '0 : pre + 1'b1;
            if (pre == PW'(REFRESH_DIV - 1))
                idx <= (idx == IW'(TOTAL_DIG - 1)) ? '0 : idx + 1'b1;
            anode   <= ~(TOTAL_DIG'(1) << idx);
            segment <= cur[4] ? SEG_DASH : seg_decode(cur[3:0]);
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: scoreboard bench for the 7-segment scan controller (default and 7-bit builds).
module tb_seven_seg_scan_ctrl;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0, in_ready, busy;
    logic [11:0] in_data = '0;
    logic [3:0]  anode;
    logic [6:0]  segment;
    logic        in_valid7 = 1'b0, in_ready7, busy7;
    logic [13:0] in_data7 = '0;
    logic [3:0]  anode7;
    logic [6:0]  segment7;

    int passed = 0;
    int total  = 0;
    logic [6:0] exp_q [$];
    logic [6:0] shown [4];

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(.NUM_CH(2), .VAL_W(6), .DIGITS_PER_CH(2), .REFRESH_DIV(RD)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .busy(busy), .anode(anode), .segment(segment)
    );

    seven_seg_scan_ctrl #(.NUM_CH(2), .VAL_W(7), .DIGITS_PER_CH(2), .REFRESH_DIV(RD)) dut7 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid7), .in_ready(in_ready7),
        .in_data(in_data7), .busy(busy7), .anode(anode7), .segment(segment7)
    );

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] model(input int v, input int pos);
        int p10 = (pos == 0) ? 1 : 10;
        if (v >= 100) return 7'b1111110;
`ifdef LEADING_ZERO_BLANK_EN
        if (pos > 0 && v < p10) return 7'h7F;
`endif
        return seg_of((v / p10) % 10);
    endfunction

    function automatic logic [3:0] an(input bit sel);
        return sel ? anode7 : anode;
    endfunction

    function automatic logic [6:0] sg(input bit sel);
        return sel ? segment7 : segment;
    endfunction

    function automatic logic rdy(input bit sel);
        return sel ? in_ready7 : in_ready;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_blank();
        for (int k = 0; k < 4; k++) exp_q.push_back(7'h7F);
    endtask

    task automatic load(input bit sel, input int c1, input int c0, input bit push);
        int n = 0;
        while (!rdy(sel) && n < 100) begin step(); n++; end
        if (sel) begin
            in_data7  = {7'(c1), 7'(c0)};
            in_valid7 = 1'b1;
        end else begin
            in_data  = {6'(c1), 6'(c0)};
            in_valid = 1'b1;
        end
        step();
        in_valid  = 1'b0;
        in_valid7 = 1'b0;
        if (push) begin
            exp_q.push_back(model(c0, 0));
            exp_q.push_back(model(c0, 1));
            exp_q.push_back(model(c1, 0));
            exp_q.push_back(model(c1, 1));
        end
    endtask

    task automatic wait_ready(input bit sel, input string name, output int n);
        n = 0;
        while (!rdy(sel) && n < 100) begin step(); n++; end
        total++;
        if (n >= 100) $display("FAIL %s_timeout: in_ready still %b after %0d cycles", name, rdy(sel), n);
        else passed++;
    endtask

    task automatic check_scan(input bit sel, input string name);
        logic [6:0] e [4];
        logic [3:0] ea;
        int n = 0;
        total++;
        if (exp_q.size() < 4) begin
            $display("FAIL %s_queue: scoreboard holds %0d entries, need 4", name, exp_q.size());
            return;
        end
        passed++;
        for (int k = 0; k < 4; k++) e[k] = exp_q.pop_front();
        while (an(sel) !== 4'b0111 && n < 64) begin step(); n++; end
        while (an(sel) !== 4'b1110 && n < 64) begin step(); n++; end
        total++;
        if (n >= 64) begin
            $display("FAIL %s_align: anode=%b, digit 0 never started", name, an(sel));
            return;
        end
        passed++;
        for (int k = 0; k < 4; k++) begin
            ea = ~(4'b0001 << k);
            for (int c = 0; c < RD; c++) begin
                total++;
                if (an(sel) !== ea || sg(sel) !== e[k])
                    $display("FAIL %s_d%0d: anode=%b seg=%b, expected anode=%b seg=%b", name, k, an(sel), sg(sel), ea, e[k]);
                else passed++;
                step();
            end
        end
        total++;
        if (an(sel) !== 4'b1110) $display("FAIL %s_wrap: anode=%b, expected 1110", name, an(sel));
        else passed++;
        if (!sel) for (int k = 0; k < 4; k++) shown[k] = e[k];
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (anode !== 4'hF || segment !== 7'h7F || in_ready !== 1'b1)
            $display("FAIL reset_hold: anode=%b seg=%b ready=%b, expected 1111 1111111 1", anode, segment, in_ready);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        total++;
        if (anode !== 4'b1110 || segment !== 7'h7F)
            $display("FAIL reset_first_digit: anode=%b seg=%b, expected 1110 1111111", anode, segment);
        else passed++;
        repeat (10) step();
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (anode !== 4'hF || segment !== 7'h7F)
            $display("FAIL reset_async: anode=%b seg=%b, expected 1111 1111111", anode, segment);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_ready: ready=%b busy=%b, expected 1 0", in_ready, busy);
        else passed++;
        push_blank();
        check_scan(0, "reset_blank");
    endtask

    task automatic test_latency();
        int n = 0;
        load(0, 23, 59, 1);
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL accept_busy: ready=%b busy=%b, expected 0 1", in_ready, busy);
        else passed++;
        while (!in_ready && n < 100) begin step(); n++; end
        total++;
        if (n != 17) $display("FAIL latency: in_ready low %0d cycles, expected 17", n);
        else passed++;
        check_scan(0, "scan_23_59");
    endtask

    task automatic test_ignore_busy();
        int n = 0;
        int k;
        load(0, 41, 7, 1);
        while (!in_ready && n < 100) begin
            if (n == 2) begin
                in_data  = {6'd12, 6'd34};
                in_valid = 1'b1;
            end
            if (n == 3) in_valid = 1'b0;
            k = -1;
            for (int j = 0; j < 4; j++) if (anode == ~(4'b0001 << j)) k = j;
            total++;
            if (k < 0) $display("FAIL busy_anode: anode=%b, expected one-hot-low", anode);
            else if (segment !== shown[k]) $display("FAIL busy_old_d%0d: seg=%b, expected %b", k, segment, shown[k]);
            else passed++;
            step();
            n++;
        end
        in_valid = 1'b0;
        total++;
        if (n != 17) $display("FAIL busy_latency: in_ready low %0d cycles, expected 17", n);
        else passed++;
        check_scan(0, "scan_41_7");
    endtask

    task automatic test_reset_mid();
        int n;
        load(0, 50, 1, 0);
        repeat (4) step();
        #2 reset_n = 1'b0;
        step();
        @(negedge clk);
        reset_n = 1'b1;
        step();
        push_blank();
        check_scan(0, "abort_blank");
        load(0, 63, 0, 1);
        wait_ready(0, "reload", n);
        check_scan(0, "scan_63_0");
    endtask

    task automatic test_leading_zero();
        int n;
        load(0, 10, 5, 1);
        wait_ready(0, "lz", n);
        check_scan(0, "scan_10_5");
    endtask

    task automatic test_overflow();
        int n;
        load(1, 99, 127, 1);
        total++;
        n = 0;
        while (!in_ready7 && n < 100) begin step(); n++; end
        if (n != 19) $display("FAIL ovf_latency: in_ready low %0d cycles, expected 19", n);
        else passed++;
        check_scan(1, "ovf_127");
        load(1, 100, 99, 1);
        wait_ready(1, "ovf2", n);
        check_scan(1, "ovf_100");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_ignore_busy();
        test_reset_mid();
        test_leading_zero();
        test_overflow();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
